modport_apb_slave: RTL and testbench

MODPORT_APB_SLAVE -- requirements
Module: modport_apb_slave

---
 rtl/modport_apb_pkg.sv | 22 ++
 rtl/modport_apb_mem.sv | 35 +++
 rtl/modport_apb_slave.sv | 108 ++++++++++
 tb/tb_modport_apb_slave.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modport_apb_pkg.sv
// Shared types and constants for the APB slave and its storage.
package modport_apb_pkg;

    // Slave-side view of the APB transfer protocol.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // The topmost words of memory accept writes only from privileged masters.
    localparam int PROT_REGION_WORDS = 16;

    // True when a word index falls inside the write-protected top region.
    function automatic logic in_prot_region(input logic [31:0] word, input int depth);
        if (depth > PROT_REGION_WORDS)
            return word >= 32'(depth - PROT_REGION_WORDS);
        else
            return 1'b1;
    endfunction

endpackage

// File: rtl/modport_apb_mem.sv
// Word-organised storage with per-byte write strobes and an asynchronous read port.
module modport_apb_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    wstrb_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // Clear every word on reset; otherwise update only the enabled byte lanes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/modport_apb_slave.sv
// APB slave with configurable wait states, address/protection checking and
// byte-strobed word memory.
module modport_apb_slave
    import modport_apb_pkg::*;
#(
    parameter int NO_OF_SLAVE_ON_BUS = 4,
    parameter int SLAVE_INDEX        = 0,
    parameter int MEM_DEPTH          = 256,
    parameter int WAIT_CYCLES        = 0
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [31:0]                   PADDR,
    input  logic [2:0]                    PPROT,
    input  logic [NO_OF_SLAVE_ON_BUS-1:0] PSELx,
    input  logic                          PWRITE,
    input  logic                          PENABLE,
    input  logic [31:0]                   PWDATA,
    input  logic [3:0]                    PSTRB,
    output logic                          PREADY,
    output logic [31:0]                   PRDATA,
    output logic                          PSLVERR
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    apb_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        sel;
    logic        ready;
    logic        err_cond;
    logic [31:0] word_idx;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        unused_bits;

    assign sel         = PSELx[SLAVE_INDEX];
    assign word_idx    = {2'b00, PADDR[31:2]};
    assign unused_bits = ^{PPROT[2:1], PSELx};

    // Completion happens only once the programmed number of wait cycles has elapsed.
    assign ready = (state_q == ACCESS) && sel && PENABLE && (cnt_q == CW'(WAIT_CYCLES));

    // Misalignment, out-of-range, unprivileged protected write, or strobed read.
    assign err_cond = (state_q == ACCESS) &&
                      ((PADDR[1:0] != 2'b00) ||
                       (word_idx >= 32'(MEM_DEPTH)) ||
                       (PWRITE && in_prot_region(word_idx, MEM_DEPTH) && !PPROT[0]) ||
                       (!PWRITE && (PSTRB != 4'h0)));

    assign PREADY  = ready;
    assign PSLVERR = ready && err_cond;
    assign PRDATA  = (ready && !PWRITE && !err_cond) ? mem_rdata : '0;
    assign mem_we  = ready && PWRITE && !err_cond;

    // State and wait counter registers; reset aborts any transfer in flight.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Transfer sequencing; a deselect during ACCESS drops the transfer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (sel && !PENABLE) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                if (!sel) begin
                    state_d = IDLE;
                end else if (ready) begin
                    state_d = (!PENABLE) ? SETUP : IDLE;
                end else if (cnt_q < CW'(WAIT_CYCLES)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    modport_apb_mem #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (PCLK),
        .rst_ni  (PRESETn),
        .we_i    (mem_we),
        .waddr_i (word_idx[AW-1:0]),
        .wdata_i (PWDATA),
        .wstrb_i (PSTRB),
        .raddr_i (word_idx[AW-1:0]),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_modport_apb_slave.sv
// Bench for modport_apb_slave: a zero-wait and a two-wait instance share one bus.
// Each transfer holds PENABLE until the slower instance completes, so both
// memories see every transfer. The first PENABLE cycle is spent in the slave's
// SETUP state, so completion is expected on enable cycle 1 + WAIT_CYCLES.
module tb_modport_apb_slave;

    localparam int NSL   = 4;
    localparam int SIDX  = 0;
    localparam int DEPTH = 256;
    localparam int W1    = 2;
    localparam int LAT0  = 1;
    localparam int LAT1  = 1 + W1;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [31:0] PADDR, PWDATA;
    logic [2:0]  PPROT;
    logic [3:0]  PSELx, PSTRB;
    logic        PWRITE, PENABLE;
    logic        rdy0, rdy1, err0, err1;
    logic [31:0] rd0, rd1;

    always #5 PCLK = ~PCLK;

    modport_apb_slave #(.NO_OF_SLAVE_ON_BUS(NSL), .SLAVE_INDEX(SIDX), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PPROT(PPROT), .PSELx(PSELx),
        .PWRITE(PWRITE), .PENABLE(PENABLE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(rdy0), .PRDATA(rd0), .PSLVERR(err0));

    modport_apb_slave #(.NO_OF_SLAVE_ON_BUS(NSL), .SLAVE_INDEX(SIDX), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(W1)) u_dut1 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PPROT(PPROT), .PSELx(PSELx),
        .PWRITE(PWRITE), .PENABLE(PENABLE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(rdy1), .PRDATA(rd1), .PSLVERR(err1));

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [DEPTH];

    logic        done0, done1, serr0, serr1;
    int          lat0, lat1;
    logic [31:0] srd0, srd1;

    // Reference: error rules stated directly in terms of address, direction, protection, strobes.
    function automatic logic exp_err(input logic wr, input logic [31:0] addr,
                                     input logic [2:0] prot, input logic [3:0] strb);
        longint unsigned w;
        w = longint'(addr >> 2);
        return (addr[1:0] != 2'b00) || (w >= DEPTH) ||
               (wr && (w >= DEPTH - 16) && !prot[0]) || (!wr && strb != 4'h0);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic wr, input logic [31:0] addr,
                                              input logic [2:0] prot, input logic [3:0] strb);
        if (wr || exp_err(wr, addr, prot, strb)) return 32'h0;
        return model[int'(addr >> 2)];
    endfunction

    task automatic model_commit(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic [2:0] prot);
        if (wr && !exp_err(wr, addr, prot, strb)) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[int'(addr >> 2)][8*b +: 8] = wdata[8*b +: 8];
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input logic [3:0] psel);
        done0 = 1'b0; done1 = 1'b0; lat0 = -1; lat1 = -1;
        srd0 = 32'h0; srd1 = 32'h0; serr0 = 1'b0; serr1 = 1'b0;
        @(posedge PCLK); #1;
        PSELx = psel; PADDR = addr; PWRITE = wr; PWDATA = wdata; PSTRB = strb; PPROT = prot;
        PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        for (int k = 0; k < 10 && !done1; k++) begin
            @(negedge PCLK);
            if (!done0 && rdy0) begin done0 = 1'b1; lat0 = k; srd0 = rd0; serr0 = err0; end
            if (!done1 && rdy1) begin done1 = 1'b1; lat1 = k; srd1 = rd1; serr1 = err1; end
            if (!done1) begin @(posedge PCLK); #1; end
        end
        @(posedge PCLK); #1;
        PSELx = '0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        PSELx = '0; PENABLE = 1'b0; PADDR = '0; PWRITE = 1'b0; PWDATA = '0; PSTRB = '0; PPROT = '0;
        model_clear();
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        n_checks++;
        if ({rdy0, err0, rd0, rdy1, err1, rd1} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b/%b err=%b/%b rd=%h/%h want all 0",
                     rdy0, rdy1, err0, err1, rd0, rd1);
        end
        PRESETn = 1'b1;
        xfer(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'b000, 4'(1 << SIDX));
        n_checks++;
        if (srd0 !== 32'h0 || srd1 !== 32'h0 || !done0 || !done1) begin
            n_fail++;
            $display("FAIL reset_mem_zero: got %h/%h done=%b/%b want 00000000 done=1/1",
                     srd0, srd1, done0, done1);
        end
    endtask

    task automatic test_zero_wait_write();
        xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b000, 4'(1 << SIDX));
        model_commit(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b000);
        n_checks++;
        if (lat0 !== LAT0 || serr0 !== 1'b0) begin
            n_fail++;
            $display("FAIL zw_write: got lat=%0d err=%b want lat=%0d err=0", lat0, serr0, LAT0);
        end
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 4'(1 << SIDX));
        n_checks++;
        if (srd0 !== 32'hDEAD_BEEF || srd1 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL zw_readback: got %h/%h want deadbeef", srd0, srd1);
        end
    endtask

    task automatic test_partial_strobe();
        xfer(1'b1, 32'h10, 32'h1122_3344, 4'h5, 3'b000, 4'(1 << SIDX));
        model_commit(1'b1, 32'h10, 32'h1122_3344, 4'h5, 3'b000);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 4'(1 << SIDX));
        n_checks++;
        if (srd0 !== 32'hDE22_BE44 || srd1 !== model[4]) begin
            n_fail++;
            $display("FAIL partial_strobe: got %h/%h want de22be44", srd0, srd1);
        end
    endtask

    task automatic test_wait_states();
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b001, 4'(1 << SIDX));
        n_checks++;
        if (lat1 !== LAT1 || srd1 !== model[4] || serr1 !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_states: got lat=%0d rd=%h err=%b want lat=%0d rd=%h err=0",
                     lat1, srd1, serr1, LAT1, model[4]);
        end
        n_checks++;
        if (lat0 !== LAT0) begin
            n_fail++;
            $display("FAIL wait_zero_inst: got lat=%0d want %0d", lat0, LAT0);
        end
    endtask

    task automatic test_errors();
        logic [31:0] a [3];
        a[0] = 32'h13; a[1] = 32'(DEPTH * 4); a[2] = 32'(250 * 4);
        for (int i = 0; i < 3; i++) begin
            xfer(1'b1, a[i], 32'hA5A5_5A5A, 4'hF, 3'b000, 4'(1 << SIDX));
            model_commit(1'b1, a[i], 32'hA5A5_5A5A, 4'hF, 3'b000);
            n_checks++;
            if (serr0 !== 1'b1 || serr1 !== 1'b1 || !done0 || !done1) begin
                n_fail++;
                $display("FAIL err_write[%0d]: got err=%b/%b done=%b/%b want 1/1 1/1",
                         i, serr0, serr1, done0, done1);
            end
        end
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 4'(1 << SIDX));
        n_checks++;
        if (srd0 !== model[4] || srd1 !== model[4]) begin
            n_fail++;
            $display("FAIL err_nowrite: got %h/%h want %h", srd0, srd1, model[4]);
        end
        xfer(1'b0, 32'(250 * 4), 32'h0, 4'h0, 3'b000, 4'(1 << SIDX));
        n_checks++;
        if (srd0 !== 32'h0 || srd1 !== 32'h0 || serr0 !== 1'b0) begin
            n_fail++;
            $display("FAIL err_word250: got %h/%h err=%b want 00000000 err=0", srd0, srd1, serr0);
        end
        xfer(1'b0, 32'h10, 32'h0, 4'h3, 3'b000, 4'(1 << SIDX));
        n_checks++;
        if (serr0 !== 1'b1 || srd0 !== 32'h0 || serr1 !== 1'b1 || srd1 !== 32'h0) begin
            n_fail++;
            $display("FAIL err_strobed_read: got err=%b/%b rd=%h/%h want 1/1 0/0", serr0, serr1, srd0, srd1);
        end
    endtask

    task automatic test_select_decode();
        xfer(1'b1, 32'h10, 32'h0BAD_0BAD, 4'hF, 3'b001, 4'(1 << (SIDX + 1)));
        n_checks++;
        if (done0 || done1) begin
            n_fail++;
            $display("FAIL decode_ready: got done=%b/%b want 0/0", done0, done1);
        end
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 4'(1 << SIDX));
        n_checks++;
        if (srd0 !== model[4] || srd1 !== model[4]) begin
            n_fail++;
            $display("FAIL decode_mem: got %h/%h want %h", srd0, srd1, model[4]);
        end
    endtask

    task automatic test_random();
        logic        wr;
        logic [31:0] addr, wdata, erd;
        logic [3:0]  strb, psel;
        logic [2:0]  prot;
        logic        e;
        int          kind;
        for (int n = 0; n < 40; n++) begin
            kind  = $urandom_range(0, 9);
            wr    = 1'($urandom);
            wdata = $urandom;
            prot  = 3'($urandom);
            psel  = 4'($urandom) | 4'(1 << SIDX);
            if (kind < 7)       addr = {22'h0, 8'($urandom_range(0, 15)), 2'b00};
            else if (kind == 7) addr = {22'h0, 8'($urandom), 2'($urandom_range(1, 3))};
            else if (kind == 8) addr = 32'($urandom_range(DEPTH, DEPTH + 100)) << 2;
            else                addr = 32'($urandom_range(DEPTH - 16, DEPTH - 1)) << 2;
            strb = wr ? 4'($urandom) : (($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0);
            e    = exp_err(wr, addr, prot, strb);
            erd  = exp_rdata(wr, addr, prot, strb);
            xfer(wr, addr, wdata, strb, prot, psel);
            model_commit(wr, addr, wdata, strb, prot);
            n_checks++;
            if (lat0 !== LAT0 || lat1 !== LAT1) begin
                n_fail++;
                $display("FAIL rand_lat[%0d]: got %0d/%0d want %0d/%0d", n, lat0, lat1, LAT0, LAT1);
            end
            n_checks++;
            if (serr0 !== e || serr1 !== e) begin
                n_fail++;
                $display("FAIL rand_err[%0d]: addr=%h wr=%b got %b/%b want %b", n, addr, wr, serr0, serr1, e);
            end
            n_checks++;
            if (srd0 !== erd || srd1 !== erd) begin
                n_fail++;
                $display("FAIL rand_rdata[%0d]: addr=%h got %h/%h want %h", n, addr, srd0, srd1, erd);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        @(posedge PCLK); #1;
        PSELx = 4'(1 << SIDX); PADDR = 32'h20; PWRITE = 1'b1; PWDATA = 32'hCAFE_F00D;
        PSTRB = 4'hF; PPROT = 3'b001; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        n_checks++;
        if (rdy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: got rdy0=%b want 1", rdy0);
        end
        #1 PRESETn = 1'b0;
        #1;
        n_checks++;
        if ({rdy0, err0, rd0, rdy1, err1, rd1} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got rdy=%b/%b err=%b/%b rd=%h/%h want all 0",
                     rdy0, rdy1, err0, err1, rd0, rd1);
        end
        PSELx = '0; PENABLE = 1'b0;
        model_clear();
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        xfer(1'b0, 32'h20, 32'h0, 4'h0, 3'b000, 4'(1 << SIDX));
        n_checks++;
        if (srd0 !== 32'h0 || srd1 !== 32'h0 || !done0 || !done1) begin
            n_fail++;
            $display("FAIL midrst_word: got %h/%h done=%b/%b want 00000000", srd0, srd1, done0, done1);
        end
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 4'(1 << SIDX));
        n_checks++;
        if (srd0 !== model[4] || srd1 !== model[4]) begin
            n_fail++;
            $display("FAIL midrst_cleared: got %h/%h want %h", srd0, srd1, model[4]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_wait_write();
        test_partial_strobe();
        test_wait_states();
        test_errors();
        test_select_decode();
        test_random();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
